// File: rtl/periph_dispatcher.sv
`timescale 1ns/1ps
// Addressed, backpressure-aware dispatcher from the FT601 receive FIFO to one of NUM_PERIPH peripherals.
// Optional stall timeout drop is enabled by defining PERIPH_DISPATCH_TIMEOUT_EN.
module periph_dispatcher #(
    parameter int NUM_PERIPH     = 8,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [WIDTH-1:0]      tx_data,
    output logic [NUM_PERIPH-1:0] tx_valid,
    input  logic [NUM_PERIPH-1:0] tx_full,
    output logic                  busy,
    output logic [15:0]           drop_count,
    output logic                  drop_pulse
);

    localparam int AW = $clog2(NUM_PERIPH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   addr_r;
    logic [AW-1:0]   in_addr_s;
    logic            addr_bad_s;
    logic            target_full_s;
    logic            xfer_s;
    logic            drop_s;
    logic            timeout_s;

    // Header decode of the word presented by the FIFO during CAPTURE.
    always_comb begin
        in_addr_s  = in_data[WIDTH-1 -: AW];
        addr_bad_s = ({1'b0, in_addr_s} >= (AW+1)'(NUM_PERIPH));
    end

    // Full flag of the latched target; other peripherals' flags are ignored.
    always_comb begin
        target_full_s = 1'b0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            target_full_s = target_full_s | ((addr_r == AW'(i)) & tx_full[i]);
        end
    end

`ifdef PERIPH_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] stall_r;

    // Stall counter: cleared on capture, counts DELIVER cycles without a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= {CW{1'b0}};
        end else if (state_r == ST_CAPTURE) begin
            stall_r <= {CW{1'b0}};
        end else if ((state_r == ST_DELIVER) && !xfer_s) begin
            stall_r <= stall_r + CW'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

    // A transfer always wins: timeout only fires while the target is still full.
    always_comb begin
        timeout_s = (state_r == ST_DELIVER) && target_full_s &&
                    (stall_r == CW'(TIMEOUT_CYCLES - 1));
    end
`else
    logic unused_timeout_s;

    // Without the timeout feature DELIVER waits indefinitely.
    always_comb begin
        timeout_s        = 1'b0;
        unused_timeout_s = (TIMEOUT_CYCLES > 0);
    end
`endif

    // Transfer and drop qualifiers.
    always_comb begin
        xfer_s = (state_r == ST_DELIVER) && !target_full_s;
        drop_s = ((state_r == ST_CAPTURE) && addr_bad_s) || timeout_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = in_empty ? ST_IDLE : ST_READ;
            ST_READ:    state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = addr_bad_s ? ST_IDLE : ST_DELIVER;
            ST_DELIVER: state_nxt_s = (xfer_s || timeout_s) ? ST_IDLE : ST_DELIVER;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet and target latch; held from capture until the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data <= {WIDTH{1'b0}};
            addr_r  <= {AW{1'b0}};
        end else if (state_r == ST_CAPTURE) begin
            tx_data <= in_data;
            addr_r  <= in_addr_s;
        end else begin
            tx_data <= tx_data;
            addr_r  <= addr_r;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 16'h0000;
        end else if (drop_s && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'h0001;
        end else begin
            drop_count <= drop_count;
        end
    end

    // Outputs decoded from the state register and latched target.
    always_comb begin
        in_rd_en   = (state_r == ST_READ);
        busy       = (state_r != ST_IDLE);
        drop_pulse = drop_s;
        tx_valid   = {NUM_PERIPH{1'b0}};
        for (int i = 0; i < NUM_PERIPH; i++) begin
            tx_valid[i] = (state_r == ST_DELIVER) && (addr_r == AW'(i)) && !tx_full[i];
        end
    end

endmodule

// File: tb/tb_periph_dispatcher.sv
`timescale 1ns/1ps
// Directed bench for periph_dispatcher: an 8-port instance with a 16-cycle timeout and a 6-port instance
// for invalid-address drops, each fed by a small FIFO model.
module tb_periph_dispatcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  v;
        logic [31:0] d;
    } ev_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  exp_valid;
    } vec_t;

    // ---------------- main DUT (8 ports) ----------------
    logic [31:0] mem [0:31];
    int          wr_p = 0;
    int          rd_p = 0;
    logic [31:0] in_data = 32'h0;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] tx_data;
    logic [7:0]  tx_valid;
    logic [7:0]  tx_full = 8'h00;
    logic        busy;
    logic [15:0] drop_count;
    logic        drop_pulse;

    assign in_empty = (wr_p == rd_p);

    always @(posedge clk) begin
        if (in_rd_en && (rd_p != wr_p)) begin
            in_data <= mem[rd_p];
            rd_p    <= rd_p + 1;
        end
    end

    periph_dispatcher #(.NUM_PERIPH(8), .WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_empty(in_empty), .in_rd_en(in_rd_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_full(tx_full), .busy(busy),
        .drop_count(drop_count), .drop_pulse(drop_pulse)
    );

    // ---------------- second DUT (6 ports) ----------------
    logic [31:0] mem2 [0:7];
    int          wr2 = 0;
    int          rd2 = 0;
    logic [31:0] in_data2 = 32'h0;
    logic        in_empty2;
    logic        in_rd_en2;
    logic [31:0] tx_data2;
    logic [5:0]  tx_valid2;
    logic [5:0]  tx_full2 = 6'h00;
    logic        busy2;
    logic [15:0] drop_count2;
    logic        drop_pulse2;

    assign in_empty2 = (wr2 == rd2);

    always @(posedge clk) begin
        if (in_rd_en2 && (rd2 != wr2)) begin
            in_data2 <= mem2[rd2];
            rd2      <= rd2 + 1;
        end
    end

    periph_dispatcher #(.NUM_PERIPH(6), .WIDTH(32), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_empty(in_empty2), .in_rd_en(in_rd_en2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_full(tx_full2), .busy(busy2),
        .drop_count(drop_count2), .drop_pulse(drop_pulse2)
    );

    // ---------------- monitors ----------------
    ev_t log_q[$];
    ev_t log2_q[$];
    int  rd_cnt = 0;
    int  dp_cnt = 0;
    int  dp_cyc = -1;
    int  dp2_cnt = 0;
    int  dp2_cyc = -1;
    int  oh_err = 0;

    always @(negedge clk) begin
        if (tx_valid != 8'h00) log_q.push_back('{cyc: cyc, v: tx_valid, d: tx_data});
        if (tx_valid2 != 6'h00) log2_q.push_back('{cyc: cyc, v: {2'b00, tx_valid2}, d: tx_data2});
        if (!$onehot0(tx_valid) || !$onehot0(tx_valid2)) oh_err = oh_err + 1;
        if (in_rd_en) rd_cnt = rd_cnt + 1;
        if (drop_pulse) begin
            dp_cnt = dp_cnt + 1;
            dp_cyc = cyc;
        end
        if (drop_pulse2) begin
            dp2_cnt = dp2_cnt + 1;
            dp2_cyc = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        mem[wr_p] = d;
        wr_p = wr_p + 1;
    endtask

    task automatic push2(input logic [31:0] d);
        mem2[wr2] = d;
        wr2 = wr2 + 1;
    endtask

    // sel 0: main delivery log, 1: second delivery log, 2: main drop pulses
    task automatic wait_for(input int sel, input int n, input int budget, input string nm);
        int got;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            got = (sel == 0) ? log_q.size() : (sel == 1) ? log2_q.size() : dp_cnt;
            if (got >= n) break;
            tick();
        end
        got = (sel == 0) ? log_q.size() : (sel == 1) ? log2_q.size() : dp_cnt;
        chk(nm, (got >= n) ? 64'd1 : 64'd0, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[8];

    initial begin
        int c0;
        int r0;
        int base;
        int dp0;

        vecs[0] = '{32'h0000_0001, 8'h01};
        vecs[1] = '{32'h2000_0001, 8'h02};
        vecs[2] = '{32'h4000_0001, 8'h04};
        vecs[3] = '{32'h6000_0001, 8'h08};
        vecs[4] = '{32'h8000_0001, 8'h10};
        vecs[5] = '{32'hA000_0001, 8'h20};
        vecs[6] = '{32'hC000_0001, 8'h40};
        vecs[7] = '{32'hE000_0001, 8'h80};

        // Reset state
        repeat (3) tick();
        chk("rst_rd_en", in_rd_en, 1'b0);
        chk("rst_valid", tx_valid, 8'h00);
        chk("rst_data", tx_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dcnt", drop_count, 16'h0);
        chk("rst_dpulse", drop_pulse, 1'b0);
        chk("rst_dcnt2", drop_count2, 16'h0);
        rst = 1'b0;
        tick();

        // Single packet latency: valid exactly 3 cycles after in_empty falls
        c0 = cyc;
        push(32'h4000_00AA);
        wait_for(0, 1, 20, "single_arrive");
        chk("single_cyc", log_q[0].cyc, c0 + 3);
        chk("single_valid", log_q[0].v, 8'h04);
        chk("single_data", log_q[0].d, 32'h4000_00AA);
        chk("single_rd_cnt", rd_cnt, 1);
        chk("single_idle", busy, 1'b0);

        // Table: one packet per address, back-to-back
        tick();
        base = log_q.size();
        c0 = cyc;
        for (int i = 0; i < 8; i++) push(vecs[i].data);
        wait_for(0, base + 8, 80, "table_arrive");
        for (int i = 0; i < 8; i++) begin
            if (base + i < log_q.size()) begin
                chk($sformatf("tbl%0d_valid", i), log_q[base+i].v, vecs[i].exp_valid);
                chk($sformatf("tbl%0d_data", i), log_q[base+i].d, vecs[i].data);
                chk($sformatf("tbl%0d_cyc", i), log_q[base+i].cyc, c0 + 3 + 4 * i);
            end
        end
        chk("table_dcnt", drop_count, 16'h0);
        tick();

        // Stall on addr 5 holds addr 1 behind it and blocks FIFO reads
        tx_full = 8'h20;
        base = log_q.size();
        r0 = rd_cnt;
        push(32'hA000_0005);
        push(32'h2000_0011);
        repeat (20) tick();
        chk("stall_rd_cnt", rd_cnt, r0 + 1);
        chk("stall_nodeliv", log_q.size(), base);
        chk("stall_busy", busy, 1'b1);
        c0 = cyc;
        tx_full = 8'h00;
        wait_for(0, base + 2, 20, "stall_arrive");
        if (log_q.size() >= base + 2) begin
            chk("stall_first_v", log_q[base].v, 8'h20);
            chk("stall_first_d", log_q[base].d, 32'hA000_0005);
            chk("stall_first_cyc", log_q[base].cyc, c0);
            chk("stall_second_v", log_q[base+1].v, 8'h02);
            chk("stall_second_cyc", log_q[base+1].cyc, c0 + 4);
        end
        tick();

        // Invalid address on the 6-port instance
        c0 = cyc;
        push2(32'hE000_0000);
        push2(32'h2000_0022);
        wait_for(1, 1, 30, "inv_arrive");
        if (log2_q.size() >= 1) begin
            chk("inv_next_v", log2_q[0].v, 8'h02);
            chk("inv_next_d", log2_q[0].d, 32'h2000_0022);
            chk("inv_next_cyc", log2_q[0].cyc, c0 + 6);
        end
        chk("inv_dp_cnt", dp2_cnt, 1);
        chk("inv_dp_cyc", dp2_cyc, c0 + 2);
        chk("inv_dcnt", drop_count2, 16'h1);
        chk("inv_log_size", log2_q.size(), 1);
        tick();

        // Stall timeout on addr 3
        tx_full = 8'h08;
        base = log_q.size();
        c0 = cyc;
        push(32'h6000_0003);
`ifdef PERIPH_DISPATCH_TIMEOUT_EN
        wait_for(2, 1, 40, "to_drop");
        chk("to_dp_cyc", dp_cyc, c0 + 18);
        chk("to_dcnt", drop_count, 16'h1);
        chk("to_nodeliv", log_q.size(), base);
        tick();
        chk("to_idle", busy, 1'b0);
        tx_full = 8'h00;
`else
        repeat (1000) tick();
        chk("nto_busy", busy, 1'b1);
        chk("nto_valid", tx_valid, 8'h00);
        chk("nto_dcnt", drop_count, 16'h0);
        chk("nto_dp", dp_cnt, 0);
        chk("nto_nodeliv", log_q.size(), base);
        c0 = cyc;
        tx_full = 8'h00;
        wait_for(0, base + 1, 10, "nto_arrive");
        if (log_q.size() >= base + 1) begin
            chk("nto_cyc", log_q[base].cyc, c0);
            chk("nto_v", log_q[base].v, 8'h08);
        end
`endif
        tick();

        // Reset during DELIVER discards the packet without counting a drop
        tx_full = 8'h10;
        base = log_q.size();
        dp0 = dp_cnt;
        push(32'h8000_0004);
        repeat (6) tick();
        chk("mr_pre_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("mr_busy", busy, 1'b0);
        chk("mr_valid", tx_valid, 8'h00);
        chk("mr_data", tx_data, 32'h0);
        chk("mr_rd_en", in_rd_en, 1'b0);
        chk("mr_dcnt", drop_count, 16'h0);
        chk("mr_dpulse", drop_pulse, 1'b0);
        rst = 1'b0;
        tx_full = 8'h00;
        tick();
        chk("mr_no_dp", dp_cnt, dp0);
        chk("mr_nodeliv", log_q.size(), base);
        c0 = cyc;
        push(32'h4000_0044);
        wait_for(0, base + 1, 20, "mr_arrive");
        if (log_q.size() >= base + 1) begin
            chk("mr_v", log_q[base].v, 8'h04);
            chk("mr_d", log_q[base].d, 32'h4000_0044);
            chk("mr_cyc", log_q[base].cyc, c0 + 3);
        end
        tick();

        chk("onehot0", oh_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
